// File: rtl/audio_pkg.sv
// Shared types for the audio clip blocks: controller states, clip index type
// and the code that blanks a seven-segment digit.
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2
    } ctrl_state_e;

    typedef logic [3:0] clip_idx_t;

    localparam clip_idx_t BLANK_DIGIT = 4'hF;

endpackage

// File: rtl/clip_controller_if.sv
// Request, sample-memory and display signals of the clip controller.
// The controller sits on the master side; the surrounding system is the slave.
interface clip_controller_if #(
    parameter int WORD_LENGTH = 16,
    parameter int CLIP_COUNT  = 4,
    parameter int ADDR_W      = 12
);
    import audio_pkg::*;

    logic                   record_req_i;
    logic                   play_req_i;
    logic                   stop_req_i;
    clip_idx_t              clip_sel_i;
    logic [WORD_LENGTH-1:0] sample_i;
    logic [ADDR_W-1:0]      mem_addr_o;
    logic                   mem_we_o;
    logic                   mem_re_o;
    logic [WORD_LENGTH-1:0] mem_wdata_o;
    logic [WORD_LENGTH-1:0] mem_rdata_i;
    logic [WORD_LENGTH-1:0] sample_o;
    logic                   sample_valid_o;
    clip_idx_t              play_clip_o;
    clip_idx_t              record_clip_o;
    logic [CLIP_COUNT-1:0]  clip_valid_o;
    logic                   busy_o;

    modport master (
        input  record_req_i, play_req_i, stop_req_i, clip_sel_i, sample_i, mem_rdata_i,
        output mem_addr_o, mem_we_o, mem_re_o, mem_wdata_o, sample_o, sample_valid_o,
        output play_clip_o, record_clip_o, clip_valid_o, busy_o
    );

    modport slave (
        output record_req_i, play_req_i, stop_req_i, clip_sel_i, sample_i, mem_rdata_i,
        input  mem_addr_o, mem_we_o, mem_re_o, mem_wdata_o, sample_o, sample_valid_o,
        input  play_clip_o, record_clip_o, clip_valid_o, busy_o
    );

endinterface

// File: rtl/sample_tick_gen.sv
// Free-running divider: one-cycle tick every DIV clocks, first tick DIV cycles
// after reset is released. Never resynchronised to anything but reset.
module sample_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic srst,
    output logic tick
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_reg;
    logic             tick_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else begin
            tick_reg <= (cnt_reg == CNT_W'(DIV - 1));
            cnt_reg  <= (cnt_reg == CNT_W'(DIV - 1)) ? '0 : cnt_reg + CNT_W'(1);
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/clip_controller.sv
// Record/playback sequencer for fixed-size clips in a shared sample memory.
// One memory strobe per sample tick; playback data is re-registered two cycles after the read.
module clip_controller
    import audio_pkg::*;
#(
    parameter int WORD_LENGTH        = 16,
    parameter int SYSTEM_FREQUENCY   = 100000000,
    parameter int SAMPLING_FREQUENCY = 1000000,
    parameter int CLIP_COUNT         = 4,
    parameter int CLIP_DEPTH         = 1024
) (
    input  logic              clock_i,
    input  logic              reset_i,
    clip_controller_if.master bus
);
    localparam int DIV    = SYSTEM_FREQUENCY / SAMPLING_FREQUENCY;
    localparam int ADDR_W = $clog2(CLIP_COUNT * CLIP_DEPTH);
    localparam int LEN_W  = $clog2(CLIP_DEPTH + 1);

    logic tick;

    sample_tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clock_i),
        .srst (reset_i),
        .tick (tick)
    );

    ctrl_state_e            state_reg, state_next;
    clip_idx_t              clip_reg, clip_next;
    clip_idx_t              play_clip_reg, play_clip_next;
    clip_idx_t              record_clip_reg, record_clip_next;
    logic [ADDR_W-1:0]      base_reg, base_next, addr_reg, addr_next;
    logic [LEN_W-1:0]       count_reg, count_next, count_inc, cur_len, len_wdata;
    logic [LEN_W-1:0]       length_reg [CLIP_COUNT];
    logic [CLIP_COUNT-1:0]  valid_reg, valid_next, sel_hit, clip_hit;
    logic                   we_reg, we_next, re_reg, re_next, len_we;
    logic                   rd_pending_reg, sample_valid_reg;
    logic [WORD_LENGTH-1:0] wdata_reg, wdata_next, sample_reg;

    // One-hot decode of the requested and the active clip; an out-of-range
    // selection decodes to all zeros, which is what makes it a no-op.
    for (genvar gi = 0; gi < CLIP_COUNT; gi++) begin : g_hit
        assign sel_hit[gi]  = (bus.clip_sel_i == clip_idx_t'(gi));
        assign clip_hit[gi] = (clip_reg == clip_idx_t'(gi));
    end

    assign count_inc = count_reg + LEN_W'(1);

    always_comb begin
        cur_len = '0;
        for (int n = 0; n < CLIP_COUNT; n++) begin
            if (clip_hit[n]) cur_len = length_reg[n];
        end
    end

    always_comb begin
        state_next = state_reg;
        clip_next  = clip_reg;
        base_next  = base_reg;
        count_next = count_reg;
        valid_next = valid_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        we_next    = 1'b0;
        re_next    = 1'b0;
        len_we     = 1'b0;
        len_wdata  = count_reg;
        unique case (state_reg)
            IDLE: begin
                if (bus.record_req_i && (|sel_hit)) begin
                    state_next = RECORD;
                    clip_next  = bus.clip_sel_i;
                    base_next  = ADDR_W'(int'(bus.clip_sel_i) * CLIP_DEPTH);
                    count_next = '0;
                    valid_next = valid_reg & ~sel_hit;
                end else if (bus.play_req_i && (|(sel_hit & valid_reg))) begin
                    state_next = PLAY;
                    clip_next  = bus.clip_sel_i;
                    base_next  = ADDR_W'(int'(bus.clip_sel_i) * CLIP_DEPTH);
                    count_next = '0;
                end
            end
            RECORD: begin
                if (bus.stop_req_i) begin
                    state_next = IDLE;
                    len_we     = 1'b1;
                    if (count_reg != '0) valid_next = valid_reg | clip_hit;
                end else if (tick) begin
                    we_next    = 1'b1;
                    addr_next  = base_reg + ADDR_W'(count_reg);
                    wdata_next = bus.sample_i;
                    count_next = count_inc;
                    if (count_inc == LEN_W'(CLIP_DEPTH)) begin
                        state_next = IDLE;
                        len_we     = 1'b1;
                        len_wdata  = count_inc;
                        valid_next = valid_reg | clip_hit;
                    end
                end
            end
            PLAY: begin
                if (bus.stop_req_i) begin
                    state_next = IDLE;
                end else if (tick) begin
                    re_next    = 1'b1;
                    addr_next  = base_reg + ADDR_W'(count_reg);
                    count_next = count_inc;
                    if (count_inc == cur_len) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        play_clip_next   = (state_next == PLAY)   ? clip_next : BLANK_DIGIT;
        record_clip_next = (state_next == RECORD) ? clip_next : BLANK_DIGIT;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_reg        <= IDLE;
            clip_reg         <= '0;
            base_reg         <= '0;
            count_reg        <= '0;
            valid_reg        <= '0;
            addr_reg         <= '0;
            wdata_reg        <= '0;
            we_reg           <= 1'b0;
            re_reg           <= 1'b0;
            play_clip_reg    <= BLANK_DIGIT;
            record_clip_reg  <= BLANK_DIGIT;
            rd_pending_reg   <= 1'b0;
            sample_valid_reg <= 1'b0;
            sample_reg       <= '0;
            for (int n = 0; n < CLIP_COUNT; n++) length_reg[n] <= '0;
        end else begin
            state_reg        <= state_next;
            clip_reg         <= clip_next;
            base_reg         <= base_next;
            count_reg        <= count_next;
            valid_reg        <= valid_next;
            addr_reg         <= addr_next;
            wdata_reg        <= wdata_next;
            we_reg           <= we_next;
            re_reg           <= re_next;
            play_clip_reg    <= play_clip_next;
            record_clip_reg  <= record_clip_next;
            // Read data path runs independently of the FSM so a read issued
            // on the exit tick still delivers its sample.
            rd_pending_reg   <= re_reg;
            sample_valid_reg <= rd_pending_reg;
            if (rd_pending_reg) sample_reg <= bus.mem_rdata_i;
            for (int n = 0; n < CLIP_COUNT; n++) begin
                if (len_we && clip_hit[n]) length_reg[n] <= len_wdata;
            end
        end
    end

    assign bus.mem_addr_o     = addr_reg;
    assign bus.mem_we_o       = we_reg;
    assign bus.mem_re_o       = re_reg;
    assign bus.mem_wdata_o    = wdata_reg;
    assign bus.sample_o       = sample_reg;
    assign bus.sample_valid_o = sample_valid_reg;
    assign bus.play_clip_o    = play_clip_reg;
    assign bus.record_clip_o  = record_clip_reg;
    assign bus.clip_valid_o   = valid_reg;
    assign bus.busy_o         = (state_reg != IDLE);

endmodule

// File: tb/tb_clip_controller.sv
// Self-checking bench for clip_controller: directed scenarios plus random
// requests, compared every cycle against a transaction-level model.
module tb_clip_controller;
    localparam int WL  = 16;
    localparam int SF  = 100;
    localparam int FS  = 10;
    localparam int DIV = SF / FS;
    localparam int CC  = 4;
    localparam int CD  = 8;
    localparam int AW  = $clog2(CC * CD);

    logic clock_i = 1'b0;
    logic reset_i = 1'b1;
    always #5 clock_i = ~clock_i;

    clip_controller_if #(.WORD_LENGTH(WL), .CLIP_COUNT(CC), .ADDR_W(AW)) bus ();

    clip_controller #(
        .WORD_LENGTH(WL), .SYSTEM_FREQUENCY(SF), .SAMPLING_FREQUENCY(FS),
        .CLIP_COUNT(CC), .CLIP_DEPTH(CD)
    ) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    int n_err = 0;
    int n_checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_err++;
        $display("FAIL %s: wait bound expired at t=%0t", nm, $time);
    endtask

    // Sample memory: write on strobe, read data one cycle after the read strobe.
    logic [WL-1:0] mem [CC*CD];
    always @(posedge clock_i) begin
        if (bus.mem_we_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
        if (bus.mem_re_o) bus.mem_rdata_i <= mem[bus.mem_addr_o];
    end

    // Transaction-level model. Cycle k counts clocks since the last reset
    // edge; a tick occupies every cycle with k > 0 and k % DIV == 0.
    typedef struct { int due; logic [WL-1:0] val; } pend_t;
    pend_t         pq[$];
    logic [WL-1:0] shadow [CC*CD];
    int            m_k = 0, m_mode = 0, m_clip = 0, m_n = 0;
    int            m_len [CC];
    bit [CC-1:0]   m_valid = '0;
    bit            m_ready = 1'b0;
    bit            e_we = 1'b0, e_re = 1'b0;
    int            e_addr = 0;
    logic [WL-1:0] e_wdata = '0;

    task automatic model_end_rec();
        m_len[m_clip]   = m_n;
        m_valid[m_clip] = (m_n != 0);
        m_mode          = 0;
    endtask

    always @(posedge clock_i) begin
        int  kb, sel;
        bit  tk;
        e_we = 1'b0;
        e_re = 1'b0;
        if (reset_i) begin
            m_ready = 1'b1;
            m_k     = 0;
            m_mode  = 0;
            m_valid = '0;
            foreach (m_len[i]) m_len[i] = 0;
            pq.delete();
        end else if (m_ready) begin
            kb  = m_k;
            m_k = m_k + 1;
            tk  = (kb > 0) && (kb % DIV == 0);
            sel = int'(bus.clip_sel_i);
            case (m_mode)
                0: begin
                    if (bus.record_req_i && sel < CC) begin
                        m_mode = 1; m_clip = sel; m_n = 0; m_valid[sel] = 1'b0;
                    end else if (bus.play_req_i && sel < CC && m_valid[sel]) begin
                        m_mode = 2; m_clip = sel; m_n = 0;
                    end
                end
                1: begin
                    if (bus.stop_req_i) model_end_rec();
                    else if (tk) begin
                        e_we = 1'b1; e_addr = m_clip * CD + m_n; e_wdata = bus.sample_i;
                        shadow[e_addr] = bus.sample_i;
                        m_n++;
                        if (m_n == CD) model_end_rec();
                    end
                end
                default: begin
                    if (bus.stop_req_i) m_mode = 0;
                    else if (tk) begin
                        e_re = 1'b1; e_addr = m_clip * CD + m_n;
                        pq.push_back('{m_k + 2, shadow[e_addr]});
                        m_n++;
                        if (m_n == m_len[m_clip]) m_mode = 0;
                    end
                end
            endcase
        end
    end

    // Per-cycle compare plus capture of strobes for the directed checks.
    logic [AW-1:0] wa[$], ra[$];
    logic [WL-1:0] wd[$], sv[$];
    always @(negedge clock_i) begin
        bit esv;
        if (m_ready) begin
            esv = (pq.size() > 0) && (pq[0].due == m_k);
            check("busy", bus.busy_o, m_mode != 0);
            check("we", bus.mem_we_o, e_we);
            check("re", bus.mem_re_o, e_re);
            check("sample_valid", bus.sample_valid_o, esv);
            check("play_clip", bus.play_clip_o, (m_mode == 2) ? m_clip : 15);
            check("record_clip", bus.record_clip_o, (m_mode == 1) ? m_clip : 15);
            check("clip_valid", bus.clip_valid_o, m_valid);
            if (e_we) begin
                check("wr_addr", bus.mem_addr_o, e_addr);
                check("wr_data", bus.mem_wdata_o, e_wdata);
            end
            if (e_re) check("rd_addr", bus.mem_addr_o, e_addr);
            if (esv) begin
                check("sample", bus.sample_o, pq[0].val);
                void'(pq.pop_front());
            end
        end
        if (bus.mem_we_o) begin wa.push_back(bus.mem_addr_o); wd.push_back(bus.mem_wdata_o); end
        if (bus.mem_re_o) ra.push_back(bus.mem_addr_o);
        if (bus.sample_valid_o) sv.push_back(bus.sample_o);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock_i);
        #1;
    endtask

    task automatic req(input bit r, input bit p, input bit s, input int sel);
        bus.record_req_i = r;
        bus.play_req_i   = p;
        bus.stop_req_i   = s;
        bus.clip_sel_i   = sel[3:0];
        cyc(1);
        bus.record_req_i = 1'b0;
        bus.play_req_i   = 1'b0;
        bus.stop_req_i   = 1'b0;
    endtask

    task automatic wait_tick();
        int b = 0;
        while (!(m_k > 0 && m_k % DIV == 0)) begin
            cyc(1);
            b++;
            if (b > 3 * DIV) begin timeout("wait_tick"); break; end
        end
    endtask

    task automatic wait_idle(input int lim);
        int b = 0;
        while (m_mode != 0) begin
            cyc(1);
            b++;
            if (b > lim) begin timeout("wait_idle"); break; end
        end
    endtask

    initial begin
        int r;
        for (int i = 0; i < CC * CD; i++) begin mem[i] = '0; shadow[i] = '0; end
        bus.record_req_i = 1'b0; bus.play_req_i = 1'b0; bus.stop_req_i = 1'b0;
        bus.clip_sel_i = '0; bus.sample_i = '0;
        cyc(3);
        check("rst_addr", bus.mem_addr_o, 0);
        check("rst_wdata", bus.mem_wdata_o, 0);
        check("rst_sample", bus.sample_o, 0);
        check("rst_play_clip", bus.play_clip_o, 4'hF);
        check("rst_record_clip", bus.record_clip_o, 4'hF);
        reset_i = 1'b0;
        cyc(2);

        // 1: record clip 2 to full depth, sample = tick number
        wa.delete(); wd.delete();
        req(1, 0, 0, 2);
        check("t1_record_clip", bus.record_clip_o, 2);
        for (int j = 0; j < CD; j++) begin
            wait_tick();
            bus.sample_i = WL'(j);
            cyc(1);
        end
        cyc(1);
        check("t1_nwr", wa.size(), CD);
        for (int i = 0; i < CD && i < wa.size(); i++) begin
            check("t1_addr", wa[i], 16 + i);
            check("t1_data", wd[i], i);
        end
        check("t1_valid", bus.clip_valid_o, 4'b0100);
        check("t1_record_blank", bus.record_clip_o, 4'hF);

        // 2: play clip 2
        sv.delete();
        req(0, 1, 0, 2);
        check("t2_play_clip", bus.play_clip_o, 2);
        wait_idle(200);
        check("t2_busy", bus.busy_o, 0);
        check("t2_play_blank", bus.play_clip_o, 4'hF);
        cyc(4);
        check("t2_nsamples", sv.size(), CD);
        for (int i = 0; i < CD && i < sv.size(); i++) check("t2_sample", sv[i], i);

        // 3: record clip 1, stop after 3 writes, then play it back
        wa.delete(); ra.delete();
        bus.sample_i = WL'($urandom);
        req(1, 0, 0, 1);
        for (int b = 0; wa.size() < 3; b++) begin
            if (b > 60) begin timeout("t3_writes"); break; end
            cyc(1);
        end
        req(0, 0, 1, 0);
        check("t3_valid", bus.clip_valid_o, 4'b0110);
        req(0, 1, 0, 1);
        wait_idle(100);
        cyc(4);
        check("t3_nrd", ra.size(), 3);
        for (int i = 0; i < 3 && i < ra.size(); i++) check("t3_rd_addr", ra[i], 8 + i);

        // 4: play of an unrecorded clip; record+play together on clip 0
        req(0, 1, 0, 3);
        cyc(1);
        check("t4_busy_ignored", bus.busy_o, 0);
        req(1, 1, 0, 0);
        check("t4_busy", bus.busy_o, 1);
        check("t4_record_clip", bus.record_clip_o, 0);
        check("t4_play_blank", bus.play_clip_o, 4'hF);
        req(0, 0, 1, 0);
        check("t4_valid_empty", bus.clip_valid_o, 4'b0110);

        // 5: stop on a tick cycle after two writes
        wa.delete();
        req(1, 0, 0, 3);
        wait_tick(); cyc(1);
        wait_tick(); cyc(1);
        wait_tick();
        bus.stop_req_i = 1'b1;
        cyc(1);
        bus.stop_req_i = 1'b0;
        cyc(2);
        check("t5_nwr", wa.size(), 2);
        check("t5_valid", bus.clip_valid_o, 4'b1110);

        // 6: reset while a read is in flight
        req(0, 1, 0, 2);
        wait_tick();
        cyc(1);
        reset_i = 1'b1;
        cyc(1);
        reset_i = 1'b0;
        check("t6_we", bus.mem_we_o, 0);
        check("t6_re", bus.mem_re_o, 0);
        check("t6_sv", bus.sample_valid_o, 0);
        check("t6_valid", bus.clip_valid_o, 0);
        check("t6_play_clip", bus.play_clip_o, 4'hF);
        check("t6_record_clip", bus.record_clip_o, 4'hF);
        req(0, 1, 0, 2);
        check("t6_play_ignored", bus.busy_o, 0);

        // Random requests, selections, stops and occasional resets
        for (int i = 0; i < 3000; i++) begin
            bus.sample_i     = WL'($urandom);
            r                = int'($urandom_range(0, 199));
            bus.record_req_i = (r < 4) || (r == 12);
            bus.play_req_i   = (r >= 4 && r <= 12);
            bus.stop_req_i   = (r >= 190);
            bus.clip_sel_i   = 4'($urandom_range(0, 5));
            reset_i          = ($urandom_range(0, 1499) == 0);
            cyc(1);
        end
        bus.record_req_i = 1'b0; bus.play_req_i = 1'b0; bus.stop_req_i = 1'b0;
        reset_i = 1'b0;
        cyc(5);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
